// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction types and floor-mask helpers for the car scheduler
// Holds no ports; masks are built 32 bits wide and trimmed by the user to NUM_FLOORS.
package elevator_pkg;
  localparam int MAX_FLOORS = 32;
  typedef logic [MAX_FLOORS-1:0] mask_t;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;
  typedef enum logic {UP, DOWN} dir_e;
  function automatic mask_t above_mask(input int unsigned f);
    return ~((mask_t'(2) << f) - mask_t'(1));
  endfunction
  function automatic mask_t below_mask(input int unsigned f);
    return (mask_t'(1) << f) - mask_t'(1);
  endfunction
endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable saturating down-counter shared by the move and door phases
// Ports: clk, rst (sync, active high), load_i strobe, val_i load value, zero_o when count is 0.
module elevator_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;
  assign zero_o = count_q == '0;
  always_comb count_d = load_i ? val_i : (zero_o ? count_q : count_q - W'(1));
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
endmodule

// File: rtl/elevator_car_scheduler.sv
// elevator_car_scheduler: SCAN floor scheduler sequencing car motion and door dwell
// Ports: clk, rst (sync, active high); REQ per-floor calls; DOOR_ALERT/WEIGHT_ALERT hold the door;
// CURRENT_FLOOR, MOVING_UP, MOVING_DOWN, DOOR_OPEN, PENDING, BUSY are all registered.
module elevator_car_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] REQ,
  input  logic                  DOOR_ALERT,
  input  logic                  WEIGHT_ALERT,
  output logic [FLOOR_W-1:0]    CURRENT_FLOOR,
  output logic                  MOVING_UP,
  output logic                  MOVING_DOWN,
  output logic                  DOOR_OPEN,
  output logic [NUM_FLOORS-1:0] PENDING,
  output logic                  BUSY
);
  localparam int TMAX = MOVE_CYCLES > DOOR_CYCLES ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, nxt_floor;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d, pend_seen, here;
  logic                    up_q, up_d, down_q, down_d, door_q, door_d, busy_q, busy_d;
  logic                    at_here, req_here, hit_nxt, t_zero, t_load;
  logic [TW-1:0]           t_val;
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f,
                                       input dir_e d);
    mask_t m;
    m = (d == UP) ? above_mask(32'(f)) : below_mask(32'(f));
    return |(p & m[NUM_FLOORS-1:0]);
  endfunction
  elevator_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(t_load),
    .val_i (t_val),
    .zero_o(t_zero)
  );
  assign here      = NUM_FLOORS'(1) << floor_q;
  // A call landing in the same cycle as a step still counts, hence REQ folded in.
  assign pend_seen = pend_q | REQ;
  assign at_here   = |(pend_q & here);
  assign req_here  = |(REQ & here);
  assign nxt_floor = dir_q == UP ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign hit_nxt   = |(pend_seen & (NUM_FLOORS'(1) << nxt_floor));
  assign pend_d    = pend_seen & ~(state_q == DOOR ? here : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= UP;
      floor_q <= '0;
      pend_q  <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      up_q    <= up_d;
      down_q  <= down_d;
      door_q  <= door_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    unique case (state_q)
      IDLE: begin
        if (at_here) state_d = DOOR;
        else if (calls_ahead(pend_q, floor_q, dir_q)) state_d = MOVE;
        else if (calls_ahead(pend_q, floor_q, dir_q == UP ? DOWN : UP)) begin
          dir_d   = dir_q == UP ? DOWN : UP;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (t_zero) begin
          floor_d = nxt_floor;
          state_d = hit_nxt ? DOOR : (calls_ahead(pend_seen, nxt_floor, dir_q) ? MOVE : IDLE);
        end
      end
      DOOR: begin
        if (!req_here && t_zero && !(DOOR_ALERT || WEIGHT_ALERT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reload on phase entry, on every expiry that stays put, and on a same-floor call at the door.
    t_load = state_d != IDLE && (state_d != state_q || t_zero || (state_q == DOOR && req_here));
    t_val  = state_d == MOVE ? TW'(MOVE_CYCLES - 1) : TW'(DOOR_CYCLES - 1);
  end
  always_comb begin
    up_d   = state_d == MOVE && dir_d == UP;
    down_d = state_d == MOVE && dir_d == DOWN;
    door_d = state_d == DOOR;
    busy_d = state_d != IDLE;
  end
  assign CURRENT_FLOOR = floor_q;
  assign MOVING_UP     = up_q;
  assign MOVING_DOWN   = down_q;
  assign DOOR_OPEN     = door_q;
  assign PENDING       = pend_q;
  assign BUSY          = busy_q;
endmodule

// File: tb/tb_elevator_car_scheduler.sv
// tb_elevator_car_scheduler: directed scenarios plus random traffic against a behavioural model
module tb_elevator_car_scheduler;
  localparam int NF = 8;
  localparam int MC = 4;
  localparam int DC = 6;
  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] REQ;
  logic          DOOR_ALERT, WEIGHT_ALERT;
  logic [2:0]    CURRENT_FLOOR;
  logic          MOVING_UP, MOVING_DOWN, DOOR_OPEN, BUSY;
  logic [NF-1:0] PENDING;
  int            n_chk = 0;
  int            n_fail = 0;
  int            ms, fl, k;
  bit            up;
  bit [NF-1:0]   pend;
  elevator_car_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(3), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .REQ(REQ), .DOOR_ALERT(DOOR_ALERT), .WEIGHT_ALERT(WEIGHT_ALERT),
    .CURRENT_FLOOR(CURRENT_FLOOR), .MOVING_UP(MOVING_UP), .MOVING_DOWN(MOVING_DOWN),
    .DOOR_OPEN(DOOR_OPEN), .PENDING(PENDING), .BUSY(BUSY)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit calls_beyond(input bit [NF-1:0] p, input int f, input bit go_up);
    for (int i = 0; i < NF; i++) if (p[i] && (go_up ? i > f : i < f)) return 1'b1;
    return 1'b0;
  endfunction
  // ms: 0 idle, 1 moving, 2 door open; k counts edges since the current dwell began.
  task automatic model_step();
    bit [NF-1:0] po, pnext;
    if (rst) begin
      ms = 0; fl = 0; up = 1'b1; k = 0; pend = '0;
      return;
    end
    po = pend | REQ;
    pnext = po;
    if (ms == 2) pnext[fl] = 1'b0;
    case (ms)
      0: begin
        if (pend[fl]) begin ms = 2; k = 0; end
        else if (calls_beyond(pend, fl, up)) begin ms = 1; k = 0; end
        else if (calls_beyond(pend, fl, !up)) begin up = !up; ms = 1; k = 0; end
      end
      1: begin
        if (k + 1 == MC) begin
          fl = up ? fl + 1 : fl - 1;
          k = 0;
          if (po[fl]) ms = 2;
          else if (!calls_beyond(po, fl, up)) ms = 0;
        end else k++;
      end
      default: begin
        if (REQ[fl]) k = 0;
        else if (k + 1 == DC) begin
          if (DOOR_ALERT || WEIGHT_ALERT) k = 0;
          else ms = 0;
        end else k++;
      end
    endcase
    pend = pnext;
  endtask
  task automatic check_all();
    chk("floor", 32'(CURRENT_FLOOR), 32'(fl));
    chk("moving_up", 32'(MOVING_UP), 32'(ms == 1 && up));
    chk("moving_down", 32'(MOVING_DOWN), 32'(ms == 1 && !up));
    chk("door_open", 32'(DOOR_OPEN), 32'(ms == 2));
    chk("pending", 32'(PENDING), 32'(pend));
    chk("busy", 32'(BUSY), 32'(ms != 0));
    chk("exclusive", 32'($countones({MOVING_UP, MOVING_DOWN, DOOR_OPEN}) > 1), 32'(0));
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  initial begin
    int n, ups, doors, moves, prev;
    bit ok;
    int seq[$];
    rst = 1'b1; REQ = '0; DOOR_ALERT = 1'b0; WEIGHT_ALERT = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_floor", 32'(CURRENT_FLOOR), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    REQ = 8'h08; tick(); REQ = '0;
    ups = 0; doors = 0;
    repeat (30) begin tick(); ups += 32'(MOVING_UP); doors += 32'(DOOR_OPEN); end
    chk("t1_up_cycles", 32'(ups), 32'(3 * MC));
    chk("t1_door_cycles", 32'(doors), 32'(DC));
    chk("t1_floor", 32'(CURRENT_FLOOR), 32'(3));
    chk("t1_idle", 32'(BUSY), 32'(0));
    REQ = 8'h40; tick(); REQ = '0;
    n = 0;
    while (CURRENT_FLOOR != 3'd4 && n < 100) begin tick(); n++; end
    chk("t2_reach4", 32'(n < 100), 32'(1));
    REQ = 8'h22; tick(); REQ = '0;
    prev = 0;
    repeat (150) begin
      tick();
      if (DOOR_OPEN && prev == 0) seq.push_back(int'(CURRENT_FLOOR));
      prev = int'(DOOR_OPEN);
    end
    chk("t2_stops", 32'(seq.size()), 32'(3));
    if (seq.size() == 3) begin
      chk("t2_stop0", 32'(seq[0]), 32'(5));
      chk("t2_stop1", 32'(seq[1]), 32'(6));
      chk("t2_stop2", 32'(seq[2]), 32'(1));
    end
    REQ = 8'h04; tick(); REQ = '0;
    n = 0;
    while (!DOOR_OPEN && n < 50) begin tick(); n++; end
    chk("t3_door", 32'(n < 50), 32'(1));
    DOOR_ALERT = 1'b1; ok = 1'b1;
    repeat (20) begin tick(); if (!DOOR_OPEN || MOVING_UP || MOVING_DOWN) ok = 1'b0; end
    chk("t3_hold", 32'(ok), 32'(1));
    DOOR_ALERT = 1'b0;
    n = 0;
    while (DOOR_OPEN && n < 20) begin tick(); n++; end
    chk("t3_close", 32'(n <= DC), 32'(1));
    REQ = 8'h04; tick(); REQ = '0;
    n = 0;
    while (!DOOR_OPEN && n < 50) begin tick(); n++; end
    chk("t4_door", 32'(n < 50), 32'(1));
    WEIGHT_ALERT = 1'b1; REQ = 8'h80; tick(); REQ = '0;
    ok = 1'b1;
    repeat (30) begin tick(); if (MOVING_UP || !DOOR_OPEN) ok = 1'b0; end
    chk("t4_hold", 32'(ok), 32'(1));
    WEIGHT_ALERT = 1'b0;
    n = 0;
    while (!MOVING_UP && n < 20) begin tick(); n++; end
    chk("t4_move", 32'(n < 20), 32'(1));
    n = 0;
    while (CURRENT_FLOOR != 3'd4 && n < 50) begin tick(); n++; end
    chk("t5_reach4", 32'(n < 50), 32'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_floor", 32'(CURRENT_FLOOR), 32'(0));
    chk("t5_pending", 32'(PENDING), 32'(0));
    chk("t5_outs", 32'({MOVING_UP, MOVING_DOWN, DOOR_OPEN, BUSY}), 32'(0));
    doors = 0; moves = 0;
    REQ = 8'h01;
    repeat (3) begin tick(); doors += 32'(DOOR_OPEN); end
    REQ = '0;
    repeat (12) begin tick(); doors += 32'(DOOR_OPEN); moves += 32'(MOVING_UP | MOVING_DOWN); end
    chk("t6_dwell", 32'(doors), 32'(DC + 1));
    chk("t6_no_motion", 32'(moves), 32'(0));
    REQ = 8'h80; tick(); REQ = '0;
    repeat (50) tick();
    chk("t6_top", 32'(CURRENT_FLOOR), 32'(7));
    repeat (3000) begin
      REQ = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : '0;
      if ($urandom_range(0, 19) == 0) DOOR_ALERT = ~DOOR_ALERT;
      if ($urandom_range(0, 29) == 0) WEIGHT_ALERT = ~WEIGHT_ALERT;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
